// File: rtl/pwm.sv
// Pushbutton-adjustable PWM generator: synchronized inc/dec buttons step the duty,
// and the period counter picks up the new duty only at the wrap. Optional debounce: PWM_DEBOUNCE_EN.
module pwm #(
   parameter int PERIOD          = 100,
   parameter int STEP            = 10,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_inc,
   input  logic pb_dec,
   output logic pwm_out
);

   localparam int DW = $clog2(PERIOD + 1);
   localparam logic [DW-1:0] PER_W  = DW'(PERIOD);
   localparam logic [DW-1:0] LAST_W = DW'(PERIOD - 1);
   localparam logic [DW-1:0] STEP_W = DW'(STEP);
   localparam logic [DW-1:0] HEAD_W = DW'(PERIOD - STEP);

   // bit 0 = inc button, bit 1 = dec button
   logic [1:0] sync1, sync2, lvl, lvl_prev, armed, evt;
   logic [1:0] valid_sr;
   logic [DW-1:0] count, duty, active_duty;

   // armed only rises once a real synchronized low has been seen, so a button
   // held through reset cannot fire until it is released and pressed again
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= '0;
         sync2    <= '0;
         valid_sr <= '0;
         armed    <= '0;
         lvl_prev <= '0;
         evt      <= '0;
      end else begin
         sync1    <= {pb_dec, pb_inc};
         sync2    <= sync1;
         valid_sr <= {valid_sr[0], 1'b1};
         armed    <= armed | (~sync2 & {2{valid_sr[1]}});
         lvl_prev <= lvl;
         evt      <= lvl & ~lvl_prev & armed;
      end
   end

`ifdef PWM_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DB_LOAD = CW'(DEBOUNCE_CYCLES);

   logic [CW-1:0] db_cnt [2];

   // down-counter reloads while the sample agrees with the accepted level
   always_ff @(posedge clk) begin
      if (rst) begin
         lvl       <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == lvl[i]) begin
               db_cnt[i] <= DB_LOAD;
            end else if (db_cnt[i] == '0) begin
               lvl[i]    <= sync2[i];
               db_cnt[i] <= DB_LOAD;
            end else begin
               db_cnt[i] <= db_cnt[i] - CW'(1);
            end
         end
      end
   end
`else
   logic unused_debounce;
   assign unused_debounce = |DEBOUNCE_CYCLES;

   always_ff @(posedge clk) begin
      if (rst) lvl <= '0;
      else     lvl <= sync2;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         duty <= '0;
      end else if (evt[0] && !evt[1]) begin
         duty <= (duty >= HEAD_W) ? PER_W : duty + STEP_W;
      end else if (evt[1] && !evt[0]) begin
         duty <= (duty <= STEP_W) ? '0 : duty - STEP_W;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         active_duty <= '0;
         pwm_out     <= 1'b0;
      end else begin
         pwm_out <= (count < active_duty);
         if (count == LAST_W) begin
            count       <= '0;
            active_duty <= duty;
         end else begin
            count <= count + DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pwm.sv
// Bench for pwm: directed and random button presses checked against a
// cycle-indexed duty model and per-period high-time counts.
module tb_pwm;

   localparam int P = 100;
   localparam int S = 10;
   localparam int HMAX = 30000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pb_inc = 1'b0;
   logic pb_dec = 1'b0;
   logic pwm_out;

   pwm #(.PERIOD(P), .STEP(S), .DEBOUNCE_CYCLES(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .pb_inc  (pb_inc),
      .pb_dec  (pb_dec),
      .pwm_out (pwm_out)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // model state: n = clock edges since the last reset edge
   int n = 0;
   int duty_m = 0;
   bit started = 1'b0;
   bit mon_rst;
   bit mon_exp;
   int duty_hist [0:HMAX-1];

   typedef struct {
      int at;
      bit inc;
      bit dec;
   } ev_t;
   ev_t pend[$];

   function automatic int apply_evt(int d, bit inc, bit dec);
      if (inc && !dec) return (d + S > P) ? P : d + S;
      if (dec && !inc) return (d < S) ? 0 : d - S;
      return d;
   endfunction

   // output after edge nn: high for the first active-duty cycles of each period;
   // the active duty of period k is the duty held just before edge k*P
   function automatic bit exp_pwm(int nn);
      int m, k, ad;
      if (nn == 0) return 1'b0;
      m  = nn - 1;
      k  = m / P;
      ad = (k == 0) ? 0 : duty_hist[k*P - 1];
      return ((m % P) < ad);
   endfunction

   always begin
      @(posedge clk);
      mon_rst = rst;
      #1;
      if (mon_rst) begin
         started = 1'b1;
         n = 0;
         duty_m = 0;
         pend.delete();
      end else if (started) begin
         n++;
         for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].at == n) begin
               duty_m = apply_evt(duty_m, pend[i].inc, pend[i].dec);
               pend.delete(i);
            end
         end
      end
      if (started && n < HMAX) begin
         duty_hist[n] = duty_m;
         mon_exp = exp_pwm(n);
         compared++;
         assert (pwm_out === mon_exp) else begin
            mismatched++;
            $error("FAIL pwm_cycle n=%0d observed=%b expected=%b", n, pwm_out, mon_exp);
         end
      end
   end

   // button held for len cycles; the duty moves 4 edges after the first sampling edge
   task automatic press(input bit inc, input bit dec, input int len);
      ev_t e;
      @(negedge clk);
      pb_inc = inc;
      pb_dec = dec;
      e.at  = n + 5;
      e.inc = inc;
      e.dec = dec;
      pend.push_back(e);
      repeat (len) @(negedge clk);
      pb_inc = 1'b0;
      pb_dec = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic align(input string tag);
      int guard = 0;
      @(negedge clk);
      while ((n % P) != 0 && guard < 2*P) begin
         @(negedge clk);
         guard++;
      end
      compared++;
      assert (guard < 2*P) else begin
         mismatched++;
         $error("FAIL %s_align observed=%0d expected_below=%0d", tag, guard, 2*P);
      end
   endtask

   task automatic count_high(input int exp_high, input string tag);
      int hi = 0;
      for (int i = 0; i < P; i++) begin
         @(negedge clk);
         if (pwm_out === 1'b1) hi++;
      end
      compared++;
      assert (hi === exp_high) else begin
         mismatched++;
         $error("FAIL %s observed_high=%0d expected_high=%0d", tag, hi, exp_high);
      end
   endtask

   task automatic measure(input int exp_high, input string tag);
      align(tag);
      count_high(exp_high, tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int op, len;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      compared++;
      assert (pwm_out === 1'b0) else begin
         mismatched++;
         $error("FAIL reset_pwm observed=%b expected=0", pwm_out);
      end
      rst = 1'b0;

      measure(0, "idle_p1");
      measure(0, "idle_p2");
      measure(0, "idle_p3");

      repeat (3) press(1'b1, 1'b0, 1);
      measure(30, "inc3");

      repeat (12) press(1'b1, 1'b0, 1);
      measure(100, "sat_high");
      press(1'b0, 1'b1, 1);
      measure(90, "dec_from_full");

      repeat (8) press(1'b0, 1'b1, 1);
      measure(10, "at_ten");
      repeat (2) press(1'b0, 1'b1, 1);
      measure(0, "dec_to_zero");
      press(1'b0, 1'b1, 1);
      measure(0, "no_underflow");

      press(1'b1, 1'b0, 1);
      press(1'b1, 1'b1, 1);
      measure(10, "simul_incdec");

      repeat (2) press(1'b1, 1'b0, 1);
      measure(30, "thirty");

      align("mid_period");
      fork
         count_high(30, "mid_period_cur");
         begin
            repeat (49) @(negedge clk);
            press(1'b1, 1'b0, 1);
         end
      join
      measure(40, "mid_period_next");

      press(1'b1, 1'b0, 20);
      measure(50, "long_hold_once");

      // reset in the high part of a period, with inc held through deassertion
      align("reset_mid");
      repeat (20) @(negedge clk);
      pb_inc = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      compared++;
      assert (pwm_out === 1'b0) else begin
         mismatched++;
         $error("FAIL reset_mid observed=%b expected=0", pwm_out);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      pb_inc = 1'b0;
      repeat (4) @(negedge clk);
      measure(0, "held_through_reset");
      press(1'b1, 1'b0, 1);
      measure(10, "press_after_reset");

      for (int i = 0; i < 40; i++) begin
         op  = int'($urandom_range(0, 2));
         len = int'($urandom_range(1, 6));
         press(op != 1, op != 0, len);
         repeat ($urandom_range(0, 40)) @(negedge clk);
         if ((i % 10) == 9) measure(duty_m, "random_period");
      end
      measure(duty_m, "random_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pwm.md
PWM -- requirements
Module: pwm

Interface
REQ-001 Parameter PERIOD, default 100: PWM period in clk cycles, legal range 2..65535.
REQ-002 Parameter STEP, default 10: duty increment/decrement per button press, in clk cycles, legal range 1..PERIOD.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: stability window in clk cycles, used only when PWM_DEBOUNCE_EN is defined.
REQ-004 Port clk  input  1: single clock; all logic on rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port pb_inc  input  1: increase-duty pushbuttons, asynchronous to clk, active-high.
REQ-007 Port pb_dec  input  1: decrease-duty pushbuttons, asynchronous to clk, active-high.
REQ-008 Port pwm_out  output  1: registered PWM waveform.

Function
REQ-009 Each of pb_inc and pb_dec SHALL pass through a 2-flop synchronizer before any use.
REQ-010 A press event SHALL be a single-cycle pulse generated on the synchronized 0->1 transition; holding a button high SHALL produce exactly one event.
REQ-011 The duty register SHALL be at least $clog2(PERIOD+1) bits wide and hold values 0..PERIOD.
REQ-012 An inc event SHALL set duty = min(duty+STEP, PERIOD), saturating with no wrap.
REQ-013 A dec event SHALL set duty = max(duty-STEP, 0), saturating with no wrap or underflow.
REQ-014 Inc and dec events in the same cycle SHALL leave duty unchanged.
REQ-015 The duty register SHALL update on the clock edge after the event pulse, giving 4 clk cycles from the first edge sampling pb high to the duty change.
REQ-016 The period counter SHALL count 0..PERIOD-1 and wrap to 0.
REQ-017 The active duty SHALL be a shadow copy of duty, loaded only when the counter wraps to 0, so that no period is truncated or glitched.
REQ-018 pwm_out SHALL be registered: next pwm_out = (counter < active_duty).
REQ-019 Duty 0 SHALL give constant low.
REQ-020 Duty PERIOD SHALL give constant high.
REQ-021 High time per period SHALL equal active_duty cycles exactly.

Reset
REQ-022 While rst=1 at a clk edge, the following SHALL be cleared to 0: counter, duty, active_duty, pwm_out, synchronizers, edge-detect history and debounce state.
REQ-023 A button held high through reset deassertion SHALL NOT produce an event until it is released and pressed again.
REQ-024 Reset mid-period SHALL abort the period immediately, with pwm_out low on the cycle after the reset edge.

Configuration
REQ-025 Macro PWM_DEBOUNCE_EN defined: each synchronized button SHALL be accepted as changed only after DEBOUNCE_CYCLES consecutive equal samples, and edge detection SHALL operate on the debounced level, adding DEBOUNCE_CYCLES cycles to the REQ-015 latency.
REQ-026 Macro PWM_DEBOUNCE_EN undefined: no debounce logic SHALL be built, and a synchronized pulse of 1 clk cycle SHALL register as a press.

Verification
REQ-027 Release rst with defaults -> pwm_out stays 0 for 3 full periods (300 cycles).
REQ-028 3 inc pulses of 1 cycle each, with no debounce -> duty 30; from the next wrap, pwm_out is high 30 and low 70 cycles per period.
REQ-029 12 inc presses -> duty saturates at 100 and pwm_out stays constant high; 1 dec -> duty 90, high 90 cycles.
REQ-030 From duty 10: 2 dec presses -> duty 0, no underflow; simultaneous inc+dec -> duty unchanged.
REQ-031 inc pressed at counter=50 with duty 30 -> current period still high exactly 30 cycles, and the next period is high 40.
REQ-032 With PWM_DEBOUNCE_EN: a glitch shorter than 16 cycles -> no duty change; a press held for 20 cycles -> duty +10 once.
